// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: byte-lane writes, reads with 1 + WAIT_CYCLES latency.
// Optional macro DSRAM_RANGE_CHECK_EN adds range_err and blocks out-of-range accesses.
module data_sram_resp #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq_mem,
   output logic        resp_valid
`ifdef DSRAM_RANGE_CHECK_EN
   ,
   output logic        range_err
`endif
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic {IDLE, WAIT} state_t;

   logic [31:0]       mem [DEPTH];

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              oor_q, oor_d;
   logic              stall_d, valid_d, range_err_d;

   logic [ADDR_W-1:0] idx_c;
   logic              oor_c;
   logic              wr_c;
   logic              rd_fire_c;
   logic [ADDR_W-1:0] rd_idx_c;
   logic              rd_zero_c;
   logic [31:0]       rd_data_c;
   logic              unused_c;

   assign idx_c    = data_sram_addr[ADDR_W+1:2];
   assign unused_c = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2], range_err_d};

`ifdef DSRAM_RANGE_CHECK_EN
   assign oor_c = |data_sram_addr[31:ADDR_W+2];
`else
   assign oor_c = 1'b0;
`endif

   // Next-state and access decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      oor_d       = oor_q;
      stall_d     = 1'b0;
      valid_d     = 1'b0;
      range_err_d = 1'b0;
      wr_c        = 1'b0;
      rd_fire_c   = 1'b0;
      rd_idx_c    = idx_q;
      rd_zero_c   = oor_q;
      case (state_q)
         IDLE: begin
            if (data_sram_en) begin
               range_err_d = oor_c;
               if (data_sram_wen != 4'b0000) begin
                  wr_c = !oor_c;
               end else if (WAIT_CYCLES == 0) begin
                  rd_fire_c = 1'b1;
                  rd_idx_c  = idx_c;
                  rd_zero_c = oor_c;
                  valid_d   = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES);
                  idx_d   = idx_c;
                  oor_d   = oor_c;
                  stall_d = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               rd_fire_c = 1'b1;
               valid_d   = 1'b1;
               state_d   = IDLE;
            end else begin
               stall_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_data_c = rd_zero_c ? 32'h0 : mem[rd_idx_c];

   // Control state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         idx_q           <= '0;
         oor_q           <= 1'b0;
         data_sram_rdata <= 32'h0;
         stallreq_mem    <= 1'b0;
         resp_valid      <= 1'b0;
`ifdef DSRAM_RANGE_CHECK_EN
         range_err       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         oor_q        <= oor_d;
         stallreq_mem <= stall_d;
         resp_valid   <= valid_d;
         if (rd_fire_c) data_sram_rdata <= rd_data_c;
`ifdef DSRAM_RANGE_CHECK_EN
         range_err    <= range_err_d;
`endif
      end
   end

   // Array is not reset; enabled lanes commit at the accepting edge
   always_ff @(posedge clk) begin
      if (wr_c) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) mem[idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: one instance with no wait states, one with three.
module tb_data_sram_resp;

   logic        clk = 1'b0;
   logic        rst0, en0, rst3, en3;
   logic [3:0]  wen0, wen3;
   logic [31:0] addr0, wdata0, rdata0, addr3, wdata3, rdata3;
   logic        stall0, valid0, stall3, valid3;
`ifdef DSRAM_RANGE_CHECK_EN
   logic        rerr0, rerr3;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst0), .data_sram_en(en0), .data_sram_wen(wen0),
      .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
      .stallreq_mem(stall0), .resp_valid(valid0)
`ifdef DSRAM_RANGE_CHECK_EN
      , .range_err(rerr0)
`endif
   );

   data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst3), .data_sram_en(en3), .data_sram_wen(wen3),
      .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
      .stallreq_mem(stall3), .resp_valid(valid3)
`ifdef DSRAM_RANGE_CHECK_EN
      , .range_err(rerr3)
`endif
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b0; rst3 = 1'b0;
      en0 = 1'b0; wen0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
      en3 = 1'b0; wen3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
      repeat (3) cyc();
      rst0 = 1'b1; rst3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({rdata0, stall0, valid0} !== 34'h0 || {rdata3, stall3, valid3} !== 34'h0) begin
            failures++;
            $display("FAIL reset_idle cyc%0d: got rd0=%h st0=%b v0=%b rd3=%h st3=%b v3=%b expected all 0",
                     i, rdata0, stall0, valid0, rdata3, stall3, valid3);
         end
         cyc();
      end
`ifdef DSRAM_RANGE_CHECK_EN
      checks++;
      if (rerr0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_range_err: got %b expected 0", rerr0);
      end
`endif
   endtask

   task automatic test_byte_lane();
      en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h10; wdata0 = 32'hAABBCCDD;
      cyc();
      checks++;
      if (valid0 !== 1'b0 || stall0 !== 1'b0 || rdata0 !== 32'h0) begin
         failures++;
         $display("FAIL write_full: got v=%b st=%b rd=%h expected v=0 st=0 rd=0", valid0, stall0, rdata0);
      end
      wen0 = 4'b0010; wdata0 = 32'h00001100;
      cyc();
      wen0 = 4'h0; wdata0 = 32'hFFFFFFFF;
      cyc();
      checks++;
      if (rdata0 !== 32'hAABB11DD || valid0 !== 1'b1 || stall0 !== 1'b0) begin
         failures++;
         $display("FAIL byte_lane_read: got rd=%h v=%b st=%b expected rd=aabb11dd v=1 st=0", rdata0, valid0, stall0);
      end
      en0 = 1'b0;
      cyc();
      checks++;
      if (rdata0 !== 32'hAABB11DD || valid0 !== 1'b0) begin
         failures++;
         $display("FAIL read_hold: got rd=%h v=%b expected rd=aabb11dd v=0", rdata0, valid0);
      end
      // asynchronous reset with no clock edge in between
      #2 rst0 = 1'b0;
      #1;
      checks++;
      if (rdata0 !== 32'h0 || valid0 !== 1'b0 || stall0 !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got rd=%h v=%b st=%b expected 0", rdata0, valid0, stall0);
      end
      rst0 = 1'b1;
      cyc();
   endtask

   task automatic test_back_to_back();
      en0 = 1'b1; wen0 = 4'hF;
      for (int i = 0; i < 3; i++) begin
         addr0 = 32'(4 * i); wdata0 = 32'(i + 1);
         cyc();
      end
      wen0 = 4'h0;
      for (int i = 0; i < 3; i++) begin
         addr0 = 32'(4 * i);
         cyc();
         checks++;
         if (rdata0 !== 32'(i + 1) || valid0 !== 1'b1 || stall0 !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back%0d: got rd=%h v=%b st=%b expected rd=%h v=1 st=0",
                     i, rdata0, valid0, stall0, 32'(i + 1));
         end
      end
      // upper address bits wrap onto word 4 unless range checking blocks them
      addr0 = 32'h0000_1010;
      cyc();
      checks++;
`ifdef DSRAM_RANGE_CHECK_EN
      if (rdata0 !== 32'h0 || valid0 !== 1'b1) begin
         failures++;
         $display("FAIL wrap_read: got rd=%h v=%b expected rd=0 v=1", rdata0, valid0);
      end
`else
      if (rdata0 !== 32'hAABB11DD || valid0 !== 1'b1) begin
         failures++;
         $display("FAIL wrap_read: got rd=%h v=%b expected rd=aabb11dd v=1", rdata0, valid0);
      end
`endif
      en0 = 1'b0;
      cyc();
      checks++;
      if (valid0 !== 1'b0 || stall0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: got v=%b st=%b expected 0 0", valid0, stall0);
      end
   endtask

   task automatic test_wait_states();
      en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h20; wdata3 = 32'hDEADBEEF;
      cyc();
      addr3 = 32'h10; wdata3 = 32'h0BADF00D;
      cyc();
      checks++;
      if (stall3 !== 1'b0 || valid3 !== 1'b0) begin
         failures++;
         $display("FAIL wait_write_nostall: got st=%b v=%b expected 0 0", stall3, valid3);
      end
      wen3 = 4'h0; addr3 = 32'h20;
      cyc();
      // changed request during WAIT must be ignored
      wen3 = 4'hF; addr3 = 32'h10; wdata3 = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (stall3 !== 1'b1 || valid3 !== 1'b0) begin
            failures++;
            $display("FAIL wait_stall%0d: got st=%b v=%b expected st=1 v=0", i, stall3, valid3);
         end
         cyc();
      end
      en3 = 1'b0;
      checks++;
      if (stall3 !== 1'b0 || valid3 !== 1'b1 || rdata3 !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL wait_resp: got st=%b v=%b rd=%h expected st=0 v=1 rd=deadbeef", stall3, valid3, rdata3);
      end
      cyc();
      checks++;
      if (valid3 !== 1'b0 || rdata3 !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL wait_hold: got v=%b rd=%h expected v=0 rd=deadbeef", valid3, rdata3);
      end
      en3 = 1'b1; wen3 = 4'h0; addr3 = 32'h10;
      cyc();
      en3 = 1'b0;
      repeat (3) cyc();
      checks++;
      if (rdata3 !== 32'h0BADF00D || valid3 !== 1'b1) begin
         failures++;
         $display("FAIL wait_ignored_write: got rd=%h v=%b expected rd=0badf00d v=1", rdata3, valid3);
      end
   endtask

   task automatic test_reset_mid_wait();
      en3 = 1'b1; wen3 = 4'h0; addr3 = 32'h20;
      cyc();
      en3 = 1'b0;
      cyc();
      checks++;
      if (stall3 !== 1'b1) begin
         failures++;
         $display("FAIL midwait_pre: got st=%b expected 1", stall3);
      end
      #2 rst3 = 1'b0;
      #1;
      checks++;
      if (stall3 !== 1'b0 || valid3 !== 1'b0 || rdata3 !== 32'h0) begin
         failures++;
         $display("FAIL midwait_reset: got st=%b v=%b rd=%h expected 0", stall3, valid3, rdata3);
      end
      rst3 = 1'b1;
      cyc();
      checks++;
      if (stall3 !== 1'b0 || valid3 !== 1'b0) begin
         failures++;
         $display("FAIL midwait_idle: got st=%b v=%b expected 0 0", stall3, valid3);
      end
      en3 = 1'b1; addr3 = 32'h20;
      cyc();
      en3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (stall3 !== 1'b1) begin
            failures++;
            $display("FAIL midwait_restall%0d: got st=%b expected 1", i, stall3);
         end
         cyc();
      end
      checks++;
      if (stall3 !== 1'b0 || valid3 !== 1'b1 || rdata3 !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL midwait_resp: got st=%b v=%b rd=%h expected st=0 v=1 rd=deadbeef", stall3, valid3, rdata3);
      end
   endtask

`ifdef DSRAM_RANGE_CHECK_EN
   task automatic test_range();
      en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h0000_1000; wdata0 = 32'h5;
      cyc();
      checks++;
      if (rerr0 !== 1'b1 || valid0 !== 1'b0) begin
         failures++;
         $display("FAIL range_write: got err=%b v=%b expected err=1 v=0", rerr0, valid0);
      end
      wen0 = 4'h0; addr0 = 32'h0;
      cyc();
      checks++;
      if (rdata0 !== 32'h1 || rerr0 !== 1'b0) begin
         failures++;
         $display("FAIL range_word0: got rd=%h err=%b expected rd=1 err=0", rdata0, rerr0);
      end
      addr0 = 32'h0000_1000;
      cyc();
      en0 = 1'b0;
      checks++;
      if (rdata0 !== 32'h0 || rerr0 !== 1'b1 || valid0 !== 1'b1) begin
         failures++;
         $display("FAIL range_read: got rd=%h err=%b v=%b expected rd=0 err=1 v=1", rdata0, rerr0, valid0);
      end
      cyc();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_byte_lane();
      test_back_to_back();
      test_wait_states();
      test_reset_mid_wait();
`ifdef DSRAM_RANGE_CHECK_EN
      test_range();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
